bram_write_fsm: RTL
===================

Name: bram_write_fsm

Overview:
- Write-back counterpart of the team's BRAM read FSM.
- Sits downstream of the compute module and upstream of a BRAM port.
- On a start request it snapshots the module's NUM_MODULE_OUTPUT result words, then writes them one per cycle to consecutive BRAM addresses from START_ADDRESS.
- Completion is reported with a level done/start handshake.

Parameters:
- DATA_WIDTH, 10, bits per result word and per BRAM word
- ADDR_WIDTH, 10, BRAM address width
- NUM_MODULE_OUTPUT, 4, number of words written per transaction (>=1)
- START_ADDRESS, 0, first BRAM address written; truncated to ADDR_WIDTH bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- module_outputs  input  NUM_MODULE_OUTPUT x DATA_WIDTH  packed result words; element 0 is written first
- write_start  input  1  level request; sampled only in IDLE and DONE
- write_done  output  1  high while in DONE
- busy  output  1  high while in WRITE
- BRAM_address  output  ADDR_WIDTH  write address
- BRAM_wdata  output  DATA_WIDTH  write data
- BRAM_we  output  1  write enable
- BRAM_enable  output  1  port enable

Behaviour:
- Registers:
  - state: IDLE, WRITE, DONE.
  - index: width $clog2(NUM_MODULE_OUTPUT+1).
  - shadow: NUM_MODULE_OUTPUT x DATA_WIDTH.
- Reset (asynchronous; also mid-transaction):
  - state=IDLE, index=0, shadow=0.
  - Outputs: write_done=0, busy=0, BRAM_we=0, BRAM_enable=0, BRAM_wdata=0, BRAM_address=START_ADDRESS[ADDR_WIDTH-1:0].
  - A partially written block is abandoned; no further writes occur.
- Outputs are combinational from registered state, index and shadow only. No input-to-output paths.
- IDLE:
  - All BRAM strobes are 0; address=START_ADDRESS.
  - On an edge with write_start=1: shadow<=module_outputs, index<=0, state<=WRITE.
  - module_outputs is don't-care after this capture edge.
- WRITE:
  - BRAM_enable=BRAM_we=1, busy=1.
  - BRAM_address=START_ADDRESS+index, modulo 2^ADDR_WIDTH (wraps silently).
  - BRAM_wdata=shadow[index].
  - Each edge: index<=index+1. When index==NUM_MODULE_OUTPUT-1, state<=DONE and index<=0 instead.
  - write_start is ignored while in WRITE.
- DONE:
  - write_done=1; strobes are 0; address=START_ADDRESS.
  - Stays in DONE while write_start=1.
  - The first edge with write_start=0 moves to IDLE.
  - A held write_start therefore never retriggers a transaction.
- Latency (start sampled at edge t0):
  - Writes land on edges t1..tN, with N=NUM_MODULE_OUTPUT.
  - write_done rises after edge tN.
  - A minimum of N+2 cycles separates back-to-back transactions, because start must drop for one cycle.
- Exactly N BRAM writes per transaction, no duplicates or gaps. BRAM_we is never high outside WRITE.
- NUM_MODULE_OUTPUT=1: a single WRITE cycle.

Decomposition:
- Shared package bram_fsm_pkg:
  - typedef enum logic [1:0] {IDLE, WRITE, DONE}.
  - localparam function for the index width.
  - This package is also used by the read FSM.
- No sub-module: the shadow register and counter are inline.
- An optional bench-only BRAM model, bram_model_sp, provides single-port synchronous write for checking.

Test Plan:
- Basic write (N=4, START=0x010, DW=10):
  - Stimulus: module_outputs={0x3FF,0x155,0x0AA,0x001} (element 3..0); pulse start 1 cycle.
  - Response: writes 0x001@0x010, 0x0AA@0x011, 0x155@0x012, 0x3FF@0x013 on 4 consecutive edges; busy=1 for exactly 4 cycles; write_done=1 on the next cycle.
- Snapshot:
  - Stimulus: change module_outputs to all 0x2A5 the cycle after start.
  - Response: the original captured values are written, not 0x2A5.
- Held start:
  - Stimulus: hold write_start=1 for 20 cycles.
  - Response: exactly 4 writes; write_done stays 1 until start drops; IDLE one cycle later; a second start then yields a new 4-write transaction.
- Address wrap (START=0x3FE, ADW=10):
  - Response: addresses are 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously after the 2nd write.
  - Response: BRAM_we drops immediately; all outputs at reset values; only 2 words written; the next start writes all 4 from START.
- Edge parameter (N=1):
  - Stimulus: start.
  - Response: a single write at START; write_done high 1 cycle later.

Source files
------------

// File: rtl/bram_fsm_pkg.sv
// Shared definitions for the BRAM read/write sequencing FSMs.
// Holds the state encoding and the sizing helper for the word index counter.
`timescale 1ns/1ps
package bram_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  // Index counter width; n+1 keeps it at least 1 bit wide when n == 1.
  function automatic int idx_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bram_write_fsm.sv
// Snapshots NUM_MODULE_OUTPUT result words on a start request and writes them
// one per cycle to consecutive BRAM addresses, then holds DONE until start drops.
`timescale 1ns/1ps
module bram_write_fsm
  import bram_fsm_pkg::*;
#(
  parameter int DATA_WIDTH        = 10,
  parameter int ADDR_WIDTH        = 10,
  parameter int NUM_MODULE_OUTPUT = 4,
  parameter int START_ADDRESS     = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_MODULE_OUTPUT*DATA_WIDTH-1:0] module_outputs,
  input  logic                                   write_start,
  output logic                                   write_done,
  output logic                                   busy,
  output logic [ADDR_WIDTH-1:0]                  BRAM_address,
  output logic [DATA_WIDTH-1:0]                  BRAM_wdata,
  output logic                                   BRAM_we,
  output logic                                   BRAM_enable,
  output logic [1:0]                             dbg_state
);

  localparam int IW = idx_width(NUM_MODULE_OUTPUT);
  localparam logic [ADDR_WIDTH-1:0] C_START = ADDR_WIDTH'(START_ADDRESS);
  localparam logic [IW-1:0]         C_LAST  = IW'(NUM_MODULE_OUTPUT - 1);

  // Handshake: write_start is a level request, only looked at in IDLE and DONE.
  // write_done stays high in DONE until write_start is seen low, so a held
  // request can never launch a second transaction.
  fsm_state_t                              r_state;
  logic [IW-1:0]                           r_index;
  logic [NUM_MODULE_OUTPUT*DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0]                   w_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_index  <= '0;
      r_shadow <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write_start) begin
            r_shadow <= module_outputs;
            r_index  <= '0;
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          if (r_index == C_LAST) begin
            r_index <= '0;
            r_state <= DONE;
          end else begin
            r_index <= r_index + 1'b1;
          end
        end
        DONE: begin
          if (!write_start) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_MODULE_OUTPUT; i++) begin
      if (r_index == IW'(i)) w_word = r_shadow[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs depend only on registered state so the BRAM port sees clean strobes.
  always_comb begin
    write_done   = 1'b0;
    busy         = 1'b0;
    BRAM_we      = 1'b0;
    BRAM_enable  = 1'b0;
    BRAM_address = C_START;
    BRAM_wdata   = '0;
    case (r_state)
      WRITE: begin
        busy         = 1'b1;
        BRAM_we      = 1'b1;
        BRAM_enable  = 1'b1;
        BRAM_address = C_START + ADDR_WIDTH'(r_index);
        BRAM_wdata   = w_word;
      end
      DONE:    write_done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule
